instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction sequencer for the TPU. It fetches 16-bit instructions from an external instruction memory, decodes the 3-bit opcode and holds the 13-bit base address. It issues the single-cycle `load_weight`, `load_input` and `store` pulses and the multi-cycle `valid` window, which drive the weight memory, unified buffer, input setup, MMU and accumulators. It replaces the ad-hoc fetch/execute FSM at the TPU top level and adds an explicit start/busy/done handshake.

## Interface
- `IMEM_DEPTH`, default 8: number of instruction words; `pc` width is `$clog2(IMEM_DEPTH)`.
- `ADDR_W`, default 13: base address width, taken from `instr[12:0]`.
- `COMPUTE_CYCLES`, default 6: number of cycles `valid` is held per COMPUTE.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `imem_addr`  out  $clog2(IMEM_DEPTH)  instruction address (= `pc`).
- `imem_data`  in  16  instruction word; combinational read of `imem_addr`.
- `base_address`  out  ADDR_W  address latched by LOAD_ADDR.
- `load_weight`  out  1  one-cycle pulse.
- `load_input`  out  1  one-cycle pulse.
- `valid`  out  1  held for COMPUTE_CYCLES cycles.
- `store`  out  1  one-cycle pulse.
- `busy`  out  1  high from FETCH through the last EXECUTE/COMPUTE cycle.
- `done`  out  1  level; program reached its end.
- `error`  out  1  level; illegal opcode (only with SEQ_HALT_ON_ILLEGAL_EN).

## Operation
- Opcodes in `instr[15:13]`:
  - 000 END, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUT, 100 COMPUTE, 101 STORE.
  - 110 and 111 are illegal.
- States: IDLE, FETCH, EXECUTE, COMPUTE, DONE, ERROR.
- IDLE/DONE/ERROR with `start`=1 → FETCH; `pc`←0, `done`←0, `error`←0.
- FETCH: `instr`←`imem_data`. Next state by opcode:
  - END → DONE.
  - COMPUTE → COMPUTE with `cnt`←0.
  - All others → EXECUTE.
- EXECUTE (one cycle): asserts the pulse for the latched opcode.
  - LOAD_ADDR sets `base_address`←`instr[ADDR_W-1:0]` at the end of the EXECUTE cycle; no pulse.
  - Then `pc`←`pc+1` and → FETCH.
- COMPUTE: `valid`=1 while `cnt`<COMPUTE_CYCLES.
  - `cnt` increments each cycle.
  - On the last cycle: `pc`←`pc+1` → FETCH.
- End of memory: after the entry at `pc`=IMEM_DEPTH-1 completes without END, → DONE (implicit END). No wrap.
- `start` while `busy`=1 is ignored.
- `base_address` persists across runs; it is cleared only by reset.
- Reset mid-operation aborts immediately; no pulse completes.

## Timing
- Reset values: state IDLE, `pc`=0, `imem_addr`=0, `base_address`=0; all 1-bit outputs 0.
- All outputs are registered state/instruction decodes; they change only on `clk` edges.
- `start` sampled at edge E0 → FETCH in cycle 1.
- Non-compute instruction: 2 cycles (FETCH, EXECUTE); its pulse is in the 2nd cycle.
- COMPUTE: 1 + COMPUTE_CYCLES cycles; `valid` begins the cycle after its FETCH.
- END: 1 cycle (FETCH); `done`=1 and `busy`=0 from the following cycle, held until `start` or reset.
- `base_address` is stable before any pulse that follows a LOAD_ADDR.

## Configuration
- `SEQ_HALT_ON_ILLEGAL_EN` defined: an illegal opcode at FETCH → ERROR.
  - `error`=1, `busy`=0, no pulses.
  - Sticky until `start` or reset.
- Not defined: an illegal opcode executes as a 2-cycle NOP (FETCH, EXECUTE, no pulse); `error` is tied to 0.

## Structure
- `tpu_pkg` holds:
  - `opcode_t` enum (3-bit) and `seq_state_t` enum;
  - `INSTR_W`=16, `OPCODE_W`=3, `ADDR_W`=13 constants.
- One sub-module: `instr_decode`, combinational.
  - Maps `instr` to one-hot `{is_end, is_ldaddr, is_ldw, is_ldi, is_comp, is_store, is_illegal}`.

## Test plan
- Standard program, in order: LOAD_ADDR 0x000F, LOAD_WEIGHT, LOAD_ADDR 0x001E, LOAD_INPUT, COMPUTE, LOAD_ADDR 0x0007, STORE, END. Start at E0:
  - `load_weight` in cycle 4 with `base_address`=15.
  - `load_input` in cycle 8 with `base_address`=30.
  - `valid` in cycles 10–15.
  - `store` in cycle 19 with `base_address`=7.
  - `done`=1 from cycle 21.
- COMPUTE_CYCLES=3, program COMPUTE, COMPUTE, END:
  - `valid` in cycles 2–4 and 6–8; the gap in cycle 5 is the second FETCH.
- Reset asserted in COMPUTE cycle 3:
  - all outputs 0 immediately.
  - The next `start` re-runs from `pc`=0.
- Memory of 8 STOREs with no END: 8 `store` pulses in cycles 2, 4, …, 16; `done`=1 from cycle 17.
- Opcode 111 at `pc`=1:
  - with the macro: `error`=1, no further pulses, `start` clears it;
  - without the macro: 2-cycle NOP, then the program continues.
- `start` held high throughout the run: no restart until DONE; then it restarts from `pc`=0.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and widths for the TPU instruction sequencer: opcodes,
// sequencer states and the one-hot decode record.
package tpu_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 3;
    localparam int ADDR_W   = 13;

    typedef enum logic [OPCODE_W-1:0] {
        OP_END         = 3'd0,
        OP_LOAD_ADDR   = 3'd1,
        OP_LOAD_WEIGHT = 3'd2,
        OP_LOAD_INPUT  = 3'd3,
        OP_COMPUTE     = 3'd4,
        OP_STORE       = 3'd5
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXECUTE,
        ST_COMPUTE,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    typedef struct packed {
        logic is_end;
        logic is_ldaddr;
        logic is_ldw;
        logic is_ldi;
        logic is_comp;
        logic is_store;
        logic is_illegal;
    } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: maps the opcode field of an instruction
// word to a one-hot decode record (opcodes 110/111 flag is_illegal).
module instr_decode
    import tpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output dec_t                o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_END:         o_dec.is_end     = 1'b1;
            OP_LOAD_ADDR:   o_dec.is_ldaddr  = 1'b1;
            OP_LOAD_WEIGHT: o_dec.is_ldw     = 1'b1;
            OP_LOAD_INPUT:  o_dec.is_ldi     = 1'b1;
            OP_COMPUTE:     o_dec.is_comp    = 1'b1;
            OP_STORE:       o_dec.is_store   = 1'b1;
            default:        o_dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// TPU instruction sequencer: fetch/execute/compute FSM with start/busy/done.
// Optional macro SEQ_HALT_ON_ILLEGAL_EN: illegal opcodes halt in ERROR instead of acting as NOPs.
module instr_sequencer
    import tpu_pkg::*;
#(
    parameter int IMEM_DEPTH     = 8,
    parameter int ADDR_W         = 13,
    parameter int COMPUTE_CYCLES = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [INSTR_W-1:0]            imem_data,
    output logic [ADDR_W-1:0]             base_address,
    output logic                          load_weight,
    output logic                          load_input,
    output logic                          valid,
    output logic                          store,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int PC_W  = $clog2(IMEM_DEPTH);
    localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);

    seq_state_t        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_operand;
    logic [ADDR_W-1:0] r_base;
    logic              r_ex_ldaddr;
    logic              r_ex_ldw;
    logic              r_ex_ldi;
    logic              r_ex_store;

    dec_t              w_dec;
    logic              w_last_pc;

    instr_decode u_decode (
        .i_opcode (imem_data[INSTR_W-1 -: OPCODE_W]),
        .o_dec    (w_dec)
    );

    assign w_last_pc = (r_pc == PC_W'(IMEM_DEPTH - 1));

    // The last memory entry finishing without END is an implicit END (no wrap).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_cnt       <= '0;
            r_operand   <= '0;
            r_base      <= '0;
            r_ex_ldaddr <= 1'b0;
            r_ex_ldw    <= 1'b0;
            r_ex_ldi    <= 1'b0;
            r_ex_store  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_pc    <= '0;
                    end
                end
                ST_FETCH: begin
                    r_operand   <= imem_data[ADDR_W-1:0];
                    r_ex_ldaddr <= w_dec.is_ldaddr;
                    r_ex_ldw    <= w_dec.is_ldw;
                    r_ex_ldi    <= w_dec.is_ldi;
                    r_ex_store  <= w_dec.is_store;
                    r_cnt       <= '0;
                    if (w_dec.is_end) begin
                        r_state <= ST_DONE;
                    end else if (w_dec.is_comp) begin
                        r_state <= ST_COMPUTE;
                    end else if (w_dec.is_illegal) begin
`ifdef SEQ_HALT_ON_ILLEGAL_EN
                        r_state <= ST_ERROR;
`else
                        r_state <= ST_EXECUTE;
`endif
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (r_ex_ldaddr) begin
                        r_base <= r_operand;
                    end
                    if (w_last_pc) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_COMPUTE: begin
                    if (r_cnt == CNT_W'(COMPUTE_CYCLES - 1)) begin
                        if (w_last_pc) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so reset clears them at once.
    assign imem_addr    = r_pc;
    assign base_address = r_base;
    assign load_weight  = (r_state == ST_EXECUTE) && r_ex_ldw;
    assign load_input   = (r_state == ST_EXECUTE) && r_ex_ldi;
    assign store        = (r_state == ST_EXECUTE) && r_ex_store;
    assign valid        = (r_state == ST_COMPUTE);
    assign busy         = (r_state == ST_FETCH) || (r_state == ST_EXECUTE) ||
                          (r_state == ST_COMPUTE);
    assign done         = (r_state == ST_DONE);
`ifdef SEQ_HALT_ON_ILLEGAL_EN
    assign error        = (r_state == ST_ERROR);
`else
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-cycle vector table for the
// standard program plus hand-written multi-cycle corner-case sequences.
module tb_instr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start3;
    logic [2:0]  imem_addr, imem_addr3;
    logic [15:0] imem [8];
    logic [15:0] imem3 [8];
    logic [15:0] imem_data, imem_data3;
    logic [12:0] base_address, base_address3;
    logic        load_weight, load_input, valid, store, busy, done, error;
    logic        load_weight3, load_input3, valid3, store3, busy3, done3, error3;
    logic [6:0]  flags, flags3;

    assign imem_data  = imem[imem_addr];
    assign imem_data3 = imem3[imem_addr3];
    assign flags  = {load_weight, load_input, valid, store, busy, done, error};
    assign flags3 = {load_weight3, load_input3, valid3, store3, busy3, done3, error3};

    instr_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data), .base_address(base_address),
        .load_weight(load_weight), .load_input(load_input), .valid(valid),
        .store(store), .busy(busy), .done(done), .error(error)
    );

    instr_sequencer #(.IMEM_DEPTH(8), .ADDR_W(13), .COMPUTE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .imem_addr(imem_addr3), .imem_data(imem_data3), .base_address(base_address3),
        .load_weight(load_weight3), .load_input(load_input3), .valid(valid3),
        .store(store3), .busy(busy3), .done(done3), .error(error3)
    );

    // Flag bits in {load_weight, load_input, valid, store, busy, done, error} order.
    localparam logic [6:0] F_LW = 7'b1000000;
    localparam logic [6:0] F_LI = 7'b0100000;
    localparam logic [6:0] F_V  = 7'b0010000;
    localparam logic [6:0] F_ST = 7'b0001000;
    localparam logic [6:0] F_B  = 7'b0000100;
    localparam logic [6:0] F_D  = 7'b0000010;
    localparam logic [6:0] F_E  = 7'b0000001;

    typedef struct {
        logic [6:0]  flags;
        logic [12:0] base;
    } vec_t;

    vec_t std_tab [22];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] a);
        return {op, a};
    endfunction

    task automatic chk(input string name, input int cyc, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: flags got %b expected %b (lw li v st busy done err)",
                     name, cyc, got, exp);
        end
    endtask

    task automatic chk_val(input string name, input int cyc, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Pulse start so it is sampled at E0; returns at the negedge inside cycle 1.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_std(input string name);
        pulse_start();
        for (int c = 1; c <= 22; c++) begin
            chk(name, c, flags, std_tab[c-1].flags);
            chk_val({name, "_base"}, c, int'(base_address), int'(std_tab[c-1].base));
            @(negedge clk);
        end
        $display("run %s: standard program, %0d checks so far", name, checks);
    endtask

    task automatic set_vec(input int c, input logic [6:0] f, input logic [12:0] b);
        std_tab[c-1].flags = f;
        std_tab[c-1].base  = b;
    endtask

    initial begin
        logic [6:0] exp;
        reset = 1'b1; start = 1'b0; start3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            imem[i]  = ins(3'd0, 13'd0);
            imem3[i] = ins(3'd0, 13'd0);
        end
        imem[0] = ins(3'd1, 13'h000F);
        imem[1] = ins(3'd2, 13'd0);
        imem[2] = ins(3'd1, 13'h001E);
        imem[3] = ins(3'd3, 13'd0);
        imem[4] = ins(3'd4, 13'd0);
        imem[5] = ins(3'd1, 13'h0007);
        imem[6] = ins(3'd5, 13'd0);
        imem[7] = ins(3'd0, 13'd0);
        imem3[0] = ins(3'd4, 13'd0);
        imem3[1] = ins(3'd4, 13'd0);

        // Expected per-cycle trace of the standard program, start sampled at E0.
        set_vec(1, F_B, 13'd0);        set_vec(2, F_B, 13'd0);
        set_vec(3, F_B, 13'd15);       set_vec(4, F_LW | F_B, 13'd15);
        set_vec(5, F_B, 13'd15);       set_vec(6, F_B, 13'd15);
        set_vec(7, F_B, 13'd30);       set_vec(8, F_LI | F_B, 13'd30);
        set_vec(9, F_B, 13'd30);
        for (int c = 10; c <= 15; c++) set_vec(c, F_V | F_B, 13'd30);
        set_vec(16, F_B, 13'd30);      set_vec(17, F_B, 13'd30);
        set_vec(18, F_B, 13'd7);       set_vec(19, F_ST | F_B, 13'd7);
        set_vec(20, F_B, 13'd7);       set_vec(21, F_D, 13'd7);
        set_vec(22, F_D, 13'd7);

        repeat (2) @(negedge clk);
        chk("reset_flags", 0, flags, 7'd0);
        chk_val("reset_base", 0, int'(base_address), 0);
        chk_val("reset_pc", 0, int'(imem_addr), 0);
        reset = 1'b0;
        $display("reset: outputs checked");

        run_std("std");

        // Rerun, then reset in the third COMPUTE cycle (cycle 12).
        pulse_start();
        chk_val("base_persist", 1, int'(base_address), 7);
        repeat (11) @(negedge clk);
        chk("pre_reset", 12, flags, F_V | F_B);
        reset = 1'b1;
        #1;
        chk("midreset_flags", 12, flags, 7'd0);
        chk_val("midreset_base", 12, int'(base_address), 0);
        chk_val("midreset_pc", 12, int'(imem_addr), 0);
        @(negedge clk) reset = 1'b0;
        $display("reset mid-compute: outputs checked");
        run_std("after_reset");

        // COMPUTE_CYCLES=3: COMPUTE, COMPUTE, END.
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp = 7'd0;
            if (c <= 9) exp |= F_B;
            if ((c >= 2 && c <= 4) || (c >= 6 && c <= 8)) exp |= F_V;
            if (c >= 10) exp |= F_D;
            chk("compute3", c, flags3, exp);
            @(negedge clk);
        end
        $display("run compute3: back-to-back COMPUTE checked");

        // Eight STOREs with no END: implicit END after the last word.
        for (int i = 0; i < 8; i++) imem[i] = ins(3'd5, 13'd0);
        pulse_start();
        for (int c = 1; c <= 18; c++) begin
            exp = 7'd0;
            if (c <= 16) exp |= F_B;
            if (c <= 16 && (c % 2) == 0) exp |= F_ST;
            if (c >= 17) exp |= F_D;
            chk("stores8", c, flags, exp);
            @(negedge clk);
        end
        chk_val("stores8_pc", 19, int'(imem_addr), 7);
        $display("run stores8: end-of-memory checked");

        // Illegal opcode 111 at pc=1.
        imem[0] = ins(3'd2, 13'd0);
        imem[1] = ins(3'd7, 13'd0);
        imem[2] = ins(3'd3, 13'd0);
        imem[3] = ins(3'd0, 13'd0);
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
`ifdef SEQ_HALT_ON_ILLEGAL_EN
            exp = (c <= 3) ? F_B : F_E;
            if (c == 2) exp |= F_LW;
`else
            exp = (c <= 7) ? F_B : F_D;
            if (c == 2) exp |= F_LW;
            if (c == 6) exp |= F_LI;
`endif
            chk("illegal", c, flags, exp);
            @(negedge clk);
        end
        $display("run illegal: opcode 111 handling checked");

        // start held high: ignored while busy, restarts from pc=0 once DONE.
        imem[0] = ins(3'd5, 13'd0);
        imem[1] = ins(3'd0, 13'd0);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            exp = 7'd0;
            if (c == 4 || c == 8) exp = F_D;
            else exp = F_B;
            if (c == 2 || c == 6) exp |= F_ST;
            chk("start_held", c, flags, exp);
            if (c == 3) chk_val("start_held_pc", c, int'(imem_addr), 1);
            if (c == 5) chk_val("restart_pc", c, int'(imem_addr), 0);
            if (c == 6) start = 1'b0;
            @(negedge clk);
        end
        $display("run start_held: restart behaviour checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
